// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
// Merges a bridged GMII receive stream with frames injected over AXI-Stream
// onto one GMII transmit port. Forwarded traffic cannot be stalled. It is
// either passed through whole or dropped whole. Injected frames are sent
// only while the forwarded side is quiet and the inter-frame gap has elapsed.
// Both sources reach the GMII pins with exactly one cycle of latency.
// Optional statistics: define GMII_TX_ARB_STATS_EN to build the drop, inject
// and abort counters. When it is undefined, those outputs read zero.
module gmii_tx_arbiter #(
   parameter int IFG_BYTES = 12,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           fwd_rxd,
   input  logic                 fwd_rx_dv,
   input  logic                 fwd_rx_er,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tuser,
   output logic [7:0]           gmii_txd,
   output logic                 gmii_tx_en,
   output logic                 gmii_tx_er,
   output logic [CNT_WIDTH-1:0] drop_count,
   output logic [CNT_WIDTH-1:0] inj_count,
   output logic [CNT_WIDTH-1:0] abort_count
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FWD       = 3'd1,
      S_INJ       = 3'd2,
      S_INJ_ABORT = 3'd3,
      S_IFG       = 3'd4
   } state_t;

   typedef enum logic {
      OWN_FWD = 1'b0,
      OWN_INJ = 1'b1
   } owner_t;

   // The gap is measured on the GMII pins. An injected frame's last byte
   // leaves one cycle after it is accepted, so a gap that follows an injected
   // frame lasts IFG_BYTES cycles in S_IFG. A forwarded frame has already put
   // one idle byte on the pins by the time its dv fall is seen, so its gap
   // needs one cycle less.
   localparam logic [7:0] GAP_INJ = 8'(IFG_BYTES);
   localparam logic [7:0] GAP_FWD = 8'(IFG_BYTES - 1);

   state_t     state;
   owner_t     owner;
   logic [7:0] gap_cnt;
   logic       fwd_dv_q;
   logic       run;
   logic       fwd_start;
   logic       accept;

   // dv_q comes out of reset high. A frame already running at release
   // therefore never looks like a start, and it drains without being sent.
   assign fwd_start = fwd_rx_dv & ~fwd_dv_q;

   // Ready is withheld in IDLE whenever the forwarded side is busy. A frame
   // being ignored also holds it low, so it can never collide with an
   // injected frame. run keeps ready low until the first edge after reset.
   assign s_axis_tready = run & ((state == S_INJ) | (state == S_INJ_ABORT) |
                                 ((state == S_IDLE) & ~fwd_rx_dv));

   assign accept = s_axis_tvalid & s_axis_tready;

   // Previous forwarded dv for start detection, plus the post-reset run flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_dv_q <= 1'b1;
         run      <= 1'b0;
      end else begin
         fwd_dv_q <= fwd_rx_dv;
         run      <= 1'b1;
      end
   end

   // Arbitration FSM with registered GMII outputs (idle bytes unless driven).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         owner      <= OWN_FWD;
         gap_cnt    <= 8'd0;
         gmii_txd   <= 8'h00;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
      end else begin
         gmii_txd   <= 8'h00;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         case (state)
            S_IDLE: begin
               if (fwd_start) begin
                  state      <= S_FWD;
                  gmii_txd   <= fwd_rxd;
                  gmii_tx_en <= fwd_rx_dv;
                  gmii_tx_er <= fwd_rx_er;
               end else if (accept) begin
                  gmii_txd   <= s_axis_tdata;
                  gmii_tx_en <= 1'b1;
                  gmii_tx_er <= s_axis_tlast & s_axis_tuser;
                  if (s_axis_tlast) begin
                     state   <= S_IFG;
                     owner   <= OWN_INJ;
                     gap_cnt <= GAP_INJ;
                  end else begin
                     state <= S_INJ;
                  end
               end
            end

            S_FWD: begin
               gmii_txd   <= fwd_rxd;
               gmii_tx_en <= fwd_rx_dv;
               gmii_tx_er <= fwd_rx_er;
               if (!fwd_rx_dv) begin
                  owner <= OWN_FWD;
                  if (IFG_BYTES > 1) begin
                     state   <= S_IFG;
                     gap_cnt <= GAP_FWD;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            S_INJ: begin
               if (s_axis_tvalid) begin
                  gmii_txd   <= s_axis_tdata;
                  gmii_tx_en <= 1'b1;
                  gmii_tx_er <= s_axis_tlast & s_axis_tuser;
                  if (s_axis_tlast) begin
                     state   <= S_IFG;
                     owner   <= OWN_INJ;
                     gap_cnt <= GAP_INJ;
                  end
               end else begin
                  // Underrun: poison the byte on the wire, then swallow the rest.
                  gmii_tx_en <= 1'b1;
                  gmii_tx_er <= 1'b1;
                  state      <= S_INJ_ABORT;
                  owner      <= OWN_INJ;
               end
            end

            S_INJ_ABORT: begin
               if (accept && s_axis_tlast) begin
                  state   <= S_IFG;
                  owner   <= OWN_INJ;
                  gap_cnt <= GAP_INJ;
               end
            end

            S_IFG: begin
               if (fwd_start && (owner == OWN_FWD)) begin
                  state      <= S_FWD;
                  gmii_txd   <= fwd_rxd;
                  gmii_tx_en <= fwd_rx_dv;
                  gmii_tx_er <= fwd_rx_er;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
                  if (gap_cnt <= 8'd1) begin
                     state <= S_IDLE;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef GMII_TX_ARB_STATS_EN
   logic drop_evt;
   logic inj_evt;
   logic abort_evt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   // A forwarded start that cannot be honoured is the whole dropped frame.
   assign drop_evt  = fwd_start & ((state == S_INJ) | (state == S_INJ_ABORT) |
                                   ((state == S_IFG) & (owner == OWN_INJ)));
   assign inj_evt   = accept & s_axis_tlast & ((state == S_IDLE) | (state == S_INJ));
   assign abort_evt = (state == S_INJ) & ~s_axis_tvalid;

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count  <= '0;
         inj_count   <= '0;
         abort_count <= '0;
      end else begin
         if (drop_evt)  drop_count  <= sat_inc(drop_count);
         if (inj_evt)   inj_count   <= sat_inc(inj_count);
         if (abort_evt) abort_count <= sat_inc(abort_count);
      end
   end
`else
   assign drop_count  = '0;
   assign inj_count   = '0;
   assign abort_count = '0;
`endif

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter
// Drives directed and random forwarded and injected traffic into
// gmii_tx_arbiter. A frame-level reference model decides ownership from
// time stamps: the output slot where the last frame ended, plus IFG_BYTES,
// tells it when injection is allowed and when a forwarded start is dropped.
module tb_gmii_tx_arbiter;
   localparam int IFG = 12;
   localparam int CW  = 4;
   localparam logic [CW-1:0] CMAX = '1;
`ifdef GMII_TX_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    fwd_rxd;
   logic          fwd_rx_dv;
   logic          fwd_rx_er;
   logic [7:0]    s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic          s_axis_tuser;
   logic [7:0]    gmii_txd;
   logic          gmii_tx_en;
   logic          gmii_tx_er;
   logic [CW-1:0] drop_count;
   logic [CW-1:0] inj_count;
   logic [CW-1:0] abort_count;

   int total = 0;
   int bad   = 0;

   always #4 clk = ~clk;

   gmii_tx_arbiter #(.IFG_BYTES(IFG), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .fwd_rxd(fwd_rxd), .fwd_rx_dv(fwd_rx_dv), .fwd_rx_er(fwd_rx_er),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .s_axis_tuser(s_axis_tuser),
      .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
      .drop_count(drop_count), .inj_count(inj_count), .abort_count(abort_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          cyc;
   int          end_slot;    // output slot of the last byte of the previous frame
   bit          last_inj;    // previous frame came from the injection side
   bit          fwd_on;      // a forwarded frame is being sent
   bit          inj_on;      // an injected frame is in progress
   bit          inj_bad;     // that injected frame underran
   bit          settle;      // first cycle after reset release
   logic        prev_dv;
   logic [CW-1:0] m_drop, m_inj, m_abort;
   logic [7:0]  e_txd;
   logic        e_en, e_er, e_tready;

   function automatic logic [CW-1:0] bump(input logic [CW-1:0] v);
      return (v == CMAX) ? v : v + CW'(1);
   endfunction

   task automatic model_reset();
      cyc = 0; end_slot = -1000; last_inj = 0; fwd_on = 0; inj_on = 0;
      inj_bad = 0; settle = 1; prev_dv = 1'b1;
      m_drop = '0; m_inj = '0; m_abort = '0;
      e_txd = 8'h00; e_en = 1'b0; e_er = 1'b0; e_tready = 1'b0;
   endtask

   task automatic take_beat();
      e_txd = s_axis_tdata; e_en = 1'b1; e_er = s_axis_tlast & s_axis_tuser;
      if (s_axis_tlast) begin
         inj_on = 0; end_slot = cyc + 1; last_inj = 1; m_inj = bump(m_inj);
      end
   endtask

   task automatic model_step();
      bit start, gap;
      start = fwd_rx_dv && !prev_dv;
      gap   = (cyc < end_slot + IFG);
      e_tready = !settle && (inj_on || (!fwd_on && !fwd_rx_dv && !gap));
      e_txd = 8'h00; e_en = 1'b0; e_er = 1'b0;
      if (settle) begin
         settle = 0;
      end else if (fwd_on) begin
         e_txd = fwd_rxd; e_en = fwd_rx_dv; e_er = fwd_rx_er;
         if (!fwd_rx_dv) begin fwd_on = 0; end_slot = cyc; last_inj = 0; end
      end else if (inj_on) begin
         if (start) m_drop = bump(m_drop);
         if (inj_bad) begin
            if (s_axis_tvalid && s_axis_tlast) begin
               inj_on = 0; end_slot = cyc + 1; last_inj = 1;
            end
         end else if (!s_axis_tvalid) begin
            e_en = 1'b1; e_er = 1'b1; inj_bad = 1; m_abort = bump(m_abort);
         end else begin
            take_beat();
         end
      end else if (start) begin
         if (gap && last_inj) m_drop = bump(m_drop);
         else begin
            fwd_on = 1; e_txd = fwd_rxd; e_en = fwd_rx_dv; e_er = fwd_rx_er;
         end
      end else if (e_tready && s_axis_tvalid) begin
         inj_on = 1; inj_bad = 0;
         take_beat();
      end
      prev_dv = fwd_rx_dv;
      cyc++;
   endtask

   // ---------------- stimulus generators ----------------
   bit rnd_en = 0;
   bit acc = 0;
   bit i_bad = 0;
   int f_len = 0, f_gap = 0, fixed_gap = 4;
   int i_len = 0, i_beat = 0, bubble_at = -1;
   int f_q[$];
   int i_q[$];

   task automatic drive();
      bit last_acc, new_beat, want;
      last_acc = acc;
      new_beat = acc;
      if (acc) begin i_len--; i_beat++; end
      if (f_len == 0) begin
         if (f_gap > 0) f_gap--;
         else if (rnd_en ? ($urandom_range(0, 5) == 0) : (f_q.size() > 0))
            f_len = rnd_en ? int'($urandom_range(6, 40)) : f_q.pop_front();
      end
      if (f_len > 0) begin
         fwd_rx_dv = 1'b1; fwd_rxd = 8'($urandom);
         fwd_rx_er = ($urandom_range(0, 20) == 0);
         f_len--;
         if (f_len == 0) f_gap = rnd_en ? int'($urandom_range(1, 16)) : fixed_gap;
      end else begin
         fwd_rx_dv = 1'b0; fwd_rxd = 8'h00; fwd_rx_er = 1'b0;
      end
      if (i_len == 0) begin
         want = rnd_en ? ($urandom_range(0, 7) == 0) : (i_q.size() > 0);
         if (want) begin
            i_len = rnd_en ? int'($urandom_range(1, 30)) : i_q.pop_front();
            i_beat = 0; new_beat = 1;
            i_bad = rnd_en && ($urandom_range(0, 3) == 0);
         end
      end
      if (i_len > 0) begin
         if (new_beat) s_axis_tdata = 8'($urandom);
         s_axis_tvalid = !(last_acc && ((i_beat == bubble_at) ||
                                        (rnd_en && $urandom_range(0, 80) == 0)));
         s_axis_tlast = (i_len == 1);
         s_axis_tuser = (i_len == 1) && i_bad;
      end else begin
         s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      end
   endtask

   task automatic step();
      drive();
      #1;
      model_step();
      check("tready", s_axis_tready, e_tready);
      acc = s_axis_tvalid && s_axis_tready;
      @(negedge clk);
      check("txd", gmii_txd, e_txd);
      check("tx_en", gmii_tx_en, e_en);
      check("tx_er", gmii_tx_er, e_er);
      check("drop_count", drop_count, STATS ? m_drop : '0);
      check("inj_count", inj_count, STATS ? m_inj : '0);
      check("abort_count", abort_count, STATS ? m_abort : '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tready"}, s_axis_tready, 1'b0);
      check({tag, "_txd"}, gmii_txd, 8'h00);
      check({tag, "_tx_en"}, gmii_tx_en, 1'b0);
      check({tag, "_tx_er"}, gmii_tx_er, 1'b0);
      check({tag, "_drop"}, drop_count, '0);
      check({tag, "_inj"}, inj_count, '0);
      check({tag, "_abort"}, abort_count, '0);
   endtask

   task automatic do_reset(input int n);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      fwd_rxd = 8'h00; fwd_rx_dv = 1'b0; fwd_rx_er = 1'b0;
      s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      s_axis_tuser = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_init");
      rst_n = 1'b1;
      repeat (5) step();

      // 64-byte forwarded frame passes through.
      f_q.push_back(64);
      repeat (80) step();

      // Two forwarded frames separated by 4 idle bytes.
      fixed_gap = 4;
      f_q.push_back(30); f_q.push_back(30);
      repeat (90) step();

      // Injected 60-byte frame, then a forwarded start inside its gap.
      i_q.push_back(60);
      for (int k = 0; k < 300 && !(i_len == 0 && i_q.size() == 0); k++) step();
      repeat (3) step();
      f_q.push_back(20);
      repeat (60) step();

      // Forwarded start and tvalid in the same idle cycle.
      f_q.push_back(30); i_q.push_back(10);
      repeat (90) step();

      // Underrun at beat 20 of a 40-beat injected frame.
      bubble_at = 20;
      i_q.push_back(40);
      repeat (90) step();
      bubble_at = -1;

      // Reset in the middle of a forwarded frame.
      f_q.push_back(50);
      repeat (10) step();
      do_reset(2);
      repeat (80) step();

      // Random mixed traffic, with a reset halfway through.
      rnd_en = 1;
      repeat (1500) step();
      do_reset(3);
      repeat (1500) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
